// File: rtl/instr_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : instr_sequencer                                                  |
// | Brief    : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with HALT/BEQ.    |
// |            Optional retired-instruction counter under SEQ_PERF_CNT_EN.      |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module instr_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [3:0]  ALU_ADD_OP = 4'b0010
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] instruction,
   input  logic [31:0] data_read,
   input  logic [31:0] src1_data,
   input  logic [31:0] src2_data,
   input  logic [31:0] alu_result,
   output logic [31:0] pc,
   output logic [1:0]  reg_src1,
   output logic [1:0]  reg_src2,
   output logic        reg_wr_en,
   output logic [1:0]  reg_wr_addr,
   output logic [31:0] reg_wr_data,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_op,
   output logic        mem_en,
   output logic        mem_rw,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        busy,
   output logic        halted,
   output logic [15:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam logic [1:0] C_CLS_ALU   = 2'b00;
   localparam logic [1:0] C_CLS_LOAD  = 2'b01;
   localparam logic [1:0] C_CLS_STORE = 2'b10;
   localparam logic [1:0] C_CLS_CTRL  = 2'b11;

   logic [1:0]  r_rst_sync;
   logic        w_rst_n;
   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_pc;
   logic [31:0] r_ir;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [31:0] r_alu_out;
   logic [31:0] r_mdr;

   logic [1:0]  w_cls;
   logic [3:0]  w_op;
   logic [31:0] w_imm;
   logic        w_is_halt;
   logic        w_is_beq;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_pc_next;
   logic        w_unused_bits;

   // Assertion is immediate; release is delayed by two clk edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rst_sync <= 2'b00;
      else        r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   assign w_cls         = r_ir[31:30];
   assign w_op          = r_ir[29:26];
   assign w_imm         = {{16{r_ir[15]}}, r_ir[15:0]};
   assign w_is_halt     = (w_cls == C_CLS_CTRL) && r_ir[29];
   assign w_is_beq      = (w_cls == C_CLS_CTRL) && !r_ir[29];
   assign w_pc_plus4    = r_pc + 32'd4;
   assign w_pc_next     = (w_is_beq && (r_a == r_b)) ? (w_pc_plus4 + {w_imm[29:0], 2'b00})
                                                     : w_pc_plus4;
   assign w_unused_bits = &{r_ir[19:16], 1'b0};

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state   <= S_IDLE;
         r_pc      <= RESET_PC;
         r_ir      <= 32'd0;
         r_a       <= 32'd0;
         r_b       <= 32'd0;
         r_alu_out <= 32'd0;
         r_mdr     <= 32'd0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_FETCH:  r_ir <= instruction;
            S_DECODE: begin
               r_a <= src1_data;
               r_b <= src2_data;
            end
            S_EXEC: begin
               r_alu_out <= alu_result;
               r_pc      <= w_pc_next;
            end
            S_MEM: if (w_cls == C_CLS_LOAD) r_mdr <= data_read;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next      = r_state;
      reg_src1    = 2'd0;
      reg_src2    = 2'd0;
      reg_wr_en   = 1'b0;
      reg_wr_addr = 2'd0;
      reg_wr_data = 32'd0;
      alu_a       = 32'd0;
      alu_b       = 32'd0;
      alu_op      = 4'd0;
      mem_en      = 1'b0;
      mem_rw      = 1'b0;
      mem_addr    = 32'd0;
      mem_wdata   = 32'd0;

      if (r_state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
         reg_src1 = r_ir[23:22];
         reg_src2 = r_ir[21:20];
      end

      case (r_state)
         S_IDLE:   if (start) w_next = S_FETCH;
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: w_next = w_is_halt ? S_HALT : S_EXEC;
         S_EXEC: begin
            alu_a = r_a;
            if (w_cls == C_CLS_LOAD || w_cls == C_CLS_STORE) begin
               alu_b  = w_imm;
               alu_op = ALU_ADD_OP;
               w_next = S_MEM;
            end else begin
               alu_b  = r_b;
               alu_op = w_op;
               w_next = (w_cls == C_CLS_ALU) ? S_WB : S_FETCH;
            end
         end
         S_MEM: begin
            mem_en    = 1'b1;
            mem_rw    = (w_cls == C_CLS_STORE);
            mem_addr  = r_alu_out;
            mem_wdata = r_b;
            w_next    = (w_cls == C_CLS_LOAD) ? S_WB : S_FETCH;
         end
         S_WB: begin
            reg_wr_en   = 1'b1;
            reg_wr_addr = r_ir[25:24];
            reg_wr_data = (w_cls == C_CLS_LOAD) ? r_mdr : r_alu_out;
            w_next      = S_FETCH;
         end
         S_HALT:   if (start) w_next = S_FETCH;
         default:  w_next = S_IDLE;
      endcase
   end

   assign pc     = r_pc;
   assign busy   = (r_state != S_IDLE) && (r_state != S_HALT);
   assign halted = (r_state == S_HALT);

`ifdef SEQ_PERF_CNT_EN
   logic [15:0] r_instr_count;
   logic        w_retire;

   // An instruction retires when control returns to FETCH from a work state.
   assign w_retire = (w_next == S_FETCH) && (r_state inside {S_EXEC, S_MEM, S_WB});

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n)      r_instr_count <= 16'd0;
      else if (w_retire) r_instr_count <= r_instr_count + 16'd1;
   end
   assign instr_count = r_instr_count;
`else
   assign instr_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_instr_sequencer                                               |
// | Brief    : Directed scoreboard bench for instr_sequencer.                   |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_instr_sequencer;
   localparam logic [31:0] HALT_WORD = 32'hE000_0000;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [31:0] instruction, data_read, src1_data, src2_data, alu_result;
   logic [31:0] pc, reg_wr_data, alu_a, alu_b, mem_addr, mem_wdata;
   logic [1:0]  reg_src1, reg_src2, reg_wr_addr;
   logic        reg_wr_en, mem_en, mem_rw, busy, halted;
   logic [3:0]  alu_op;
   logic [15:0] instr_count;

   logic [31:0] rf [4];
   logic [31:0] t_addr  = 32'd0;
   logic [31:0] t_instr = 32'hE000_0000;
   logic [31:0] t_data  = 32'd0;
   logic [31:0] cur_pc  = 32'd0;
   int          exp_cnt = 0;
   int          cyc = 0, base_cyc = 0, tests = 0, fails = 0;

   typedef struct {
      bit          is_mem;
      bit          rw;
      logic [31:0] addr;
      logic [31:0] data;
      int          rel;
   } ev_t;
   ev_t q[$];

   instr_sequencer #(.RESET_PC(32'h0000_0000), .ALU_ADD_OP(4'b0010)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .instruction(instruction),
      .data_read(data_read), .src1_data(src1_data), .src2_data(src2_data),
      .alu_result(alu_result), .pc(pc), .reg_src1(reg_src1), .reg_src2(reg_src2),
      .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .mem_en(mem_en), .mem_rw(mem_rw),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .halted(halted),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory, register bank and ALU environment models.
   assign data_read = t_data;
   always_comb begin
      instruction = (pc == t_addr) ? t_instr : HALT_WORD;
      src1_data   = rf[reg_src1];
      src2_data   = rf[reg_src2];
   end
   always_comb begin
      alu_result = 32'd0;
      case (alu_op)
         4'b0010: alu_result = alu_a + alu_b;
         4'b0110: alu_result = alu_a - alu_b;
         4'b0000: alu_result = alu_a & alu_b;
         4'b0001: alu_result = alu_a | alu_b;
         default: alu_result = 32'd0;
      endcase
   end

   function automatic logic [31:0] enc(input logic [1:0] cls, input logic [3:0] op,
                                       input logic [1:0] rd, input logic [1:0] rs,
                                       input logic [1:0] rt, input logic [15:0] imm);
      return {cls, op, rd, rs, rt, 4'b0000, imm};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic exp_reg(input logic [31:0] addr, input logic [31:0] data, input int rel);
      ev_t e;
      e.is_mem = 1'b0; e.rw = 1'b0; e.addr = addr; e.data = data; e.rel = rel;
      q.push_back(e);
   endtask

   task automatic exp_mem(input bit rw, input logic [31:0] addr, input logic [31:0] data,
                          input int rel);
      ev_t e;
      e.is_mem = 1'b1; e.rw = rw; e.addr = addr; e.data = data; e.rel = rel;
      q.push_back(e);
   endtask

   task automatic mon_event(input bit is_mem);
      ev_t e;
      if (q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL unexpected_event: got %s strobe at cycle %0d required none",
                  is_mem ? "mem_en" : "reg_wr_en", cyc - base_cyc);
      end else begin
         e = q.pop_front();
         check("ev_kind", {31'd0, is_mem}, {31'd0, e.is_mem});
         if (is_mem) begin
            check("mem_rw", {31'd0, mem_rw}, {31'd0, e.rw});
            check("mem_addr", mem_addr, e.addr);
            check("mem_wdata", mem_wdata, e.data);
         end else begin
            check("reg_wr_addr", {30'd0, reg_wr_addr}, e.addr);
            check("reg_wr_data", reg_wr_data, e.data);
         end
         check("ev_cycle", cyc - base_cyc, e.rel);
      end
   endtask

   always @(negedge clk) begin
      if (reg_wr_en) mon_event(1'b0);
      if (mem_en)    mon_event(1'b1);
   end

   // Issue one instruction from IDLE/HALT and wait for the HALT that follows it.
   task automatic run(input string name, input logic [31:0] instr, input int lat,
                      input logic [31:0] exp_pc, input bit retires);
      int c0;
      bit done;
      done    = 1'b0;
      t_addr  = cur_pc;
      t_instr = instr;
      @(posedge clk); #1;
      c0 = cyc; base_cyc = c0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({name, "_busy_fetch"}, {31'd0, busy}, 32'd1);
      check({name, "_halted_fetch"}, {31'd0, halted}, 32'd0);
      for (int i = 0; i < 30 && !done; i++) begin
         start = (cyc == c0 + 2);
         @(posedge clk); #1;
         if (halted) done = 1'b1;
      end
      start = 1'b0;
`ifdef SEQ_PERF_CNT_EN
      if (retires) exp_cnt++;
`endif
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got no halt required halt within 30 cycles", name);
      end else begin
         check({name, "_latency"}, cyc - c0, lat + 3);
      end
      check({name, "_pc"}, pc, exp_pc);
      check({name, "_busy_halt"}, {31'd0, busy}, 32'd0);
      check({name, "_count"}, {16'd0, instr_count}, exp_cnt);
      check({name, "_pending"}, q.size(), 32'd0);
      cur_pc = exp_pc;
   endtask

   initial begin
      int c0;
      rf[0] = 0; rf[1] = 0; rf[2] = 0; rf[3] = 0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pc", pc, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_strobes", {29'd0, reg_wr_en, mem_en, mem_rw}, 32'd0);
      check("rst_count", {16'd0, instr_count}, 32'd0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("idle_busy", {31'd0, busy}, 32'd0);

      rf[2] = 32'd5; rf[3] = 32'd7;
      exp_reg(32'd1, 32'd12, 4);
      run("alu_add", enc(2'b00, 4'b0010, 2'd1, 2'd2, 2'd3, 16'h0000), 4, 32'h4, 1'b1);

      rf[0] = 32'h0; rf[1] = 32'h100; t_data = 32'hDEAD;
      exp_mem(1'b0, 32'hFC, 32'h0, 4);
      exp_reg(32'd2, 32'hDEAD, 5);
      run("load", enc(2'b01, 4'b0000, 2'd2, 2'd1, 2'd0, 16'hFFFC), 5, 32'h8, 1'b1);

      rf[0] = 32'h20; rf[3] = 32'h55;
      exp_mem(1'b1, 32'h28, 32'h55, 4);
      run("store", enc(2'b10, 4'b0000, 2'd0, 2'd0, 2'd3, 16'h0008), 4, 32'hC, 1'b1);

      rf[1] = 32'h30; rf[2] = 32'h10;
      exp_reg(32'd0, 32'h20, 4);
      run("alu_sub", enc(2'b00, 4'b0110, 2'd0, 2'd1, 2'd2, 16'h0000), 4, 32'h10, 1'b1);

      rf[1] = 32'h77; rf[2] = 32'h77;
      run("beq_taken", enc(2'b11, 4'b0000, 2'd0, 2'd1, 2'd2, 16'hFFFE), 3, 32'hC, 1'b1);

      rf[0] = 32'hF0; rf[3] = 32'h0F;
      exp_reg(32'd2, 32'hFF, 4);
      run("alu_or", enc(2'b00, 4'b0001, 2'd2, 2'd0, 2'd3, 16'h0000), 4, 32'h10, 1'b1);

      rf[1] = 32'h1; rf[2] = 32'h2;
      run("beq_not", enc(2'b11, 4'b0000, 2'd0, 2'd1, 2'd2, 16'hFFFE), 3, 32'h14, 1'b1);

      rf[1] = 32'h9; rf[2] = 32'h9;
      run("beq_far", enc(2'b11, 4'b0000, 2'd0, 2'd1, 2'd2, 16'hFFF9), 3, 32'hFFFF_FFFC, 1'b1);

      rf[0] = 32'h1; rf[1] = 32'h2;
      exp_reg(32'd3, 32'h3, 4);
      run("alu_wrap", enc(2'b00, 4'b0010, 2'd3, 2'd0, 2'd1, 16'h0000), 4, 32'h0, 1'b1);

      run("halt_restart", HALT_WORD, 0, 32'h0, 1'b0);

      // Reset while a STORE sits in MEM.
      rf[0] = 32'h20; rf[3] = 32'h55;
      t_addr  = cur_pc;
      t_instr = enc(2'b10, 4'b0000, 2'd0, 2'd0, 2'd3, 16'h0008);
      @(posedge clk); #1;
      c0 = cyc; base_cyc = c0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 10 && cyc < c0 + 4; i++) begin
         @(posedge clk); #1;
      end
      check("mid_mem_en_before", {31'd0, mem_en}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("mid_mem_en", {31'd0, mem_en}, 32'd0);
      check("mid_strobes", {30'd0, reg_wr_en, mem_rw}, 32'd0);
      check("mid_busy", {31'd0, busy}, 32'd0);
      check("mid_halted", {31'd0, halted}, 32'd0);
      check("mid_pc", pc, 32'd0);
      check("mid_count", {16'd0, instr_count}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      check("post_rst_pc", pc, 32'd0);
      cur_pc  = 32'd0;
      exp_cnt = 0;

      rf[2] = 32'd5; rf[3] = 32'd7;
      exp_reg(32'd1, 32'd12, 4);
      run("cnt_alu", enc(2'b00, 4'b0010, 2'd1, 2'd2, 2'd3, 16'h0000), 4, 32'h4, 1'b1);

      rf[0] = 32'h1000; rf[3] = 32'hA5A5;
      exp_mem(1'b1, 32'hFF8, 32'hA5A5, 4);
      run("cnt_store", enc(2'b10, 4'b0000, 2'd0, 2'd0, 2'd3, 16'hFFF8), 4, 32'h8, 1'b1);

      rf[1] = 32'h3; rf[2] = 32'h4;
      run("cnt_beq", enc(2'b11, 4'b0000, 2'd0, 2'd1, 2'd2, 16'h0004), 3, 32'hC, 1'b1);

      check("final_pending", q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion required finish before 200000 time units");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
